freq_to_note: RTL and testbench

//   Inverse of the note/octave -> frequency calculator. Takes an integer frequency
//   in Hz and returns the nearest equal-tempered note (C..B) and octave over C3..B6.

---
 rtl/freq_to_note.sv | 174 +++++++++++++++++
 tb/tb_freq_to_note.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/freq_to_note.sv
// freq_to_note: maps an integer frequency in Hz to the nearest equal-tempered
// note (C..B) and octave over C3..B6. The search is sequential: one candidate
// of the 48-entry x100 semitone grid is evaluated per clock. Inputs and outputs
// use a valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid to capture freq_in
//   SCAN  | one candidate per edge, k=0..47, tracking the closest so far
//   DONE  | out_valid=1, result held until out_ready
module freq_to_note #(
  parameter int FMIN_HZ = 127,
  parameter int FMAX_HZ = 2034
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] freq_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  note,
  output logic [1:0]  octave,
  output logic        sharp,
  output logic        out_range
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [19:0] LP_FMIN = 20'(FMIN_HZ);
  localparam logic [19:0] LP_FMAX = 20'(FMAX_HZ);

  state_t      r_state;
  logic [26:0] r_f100;
  logic        r_range;
  logic [26:0] r_best_diff;
  logic [3:0]  r_best_note;
  logic [1:0]  r_best_oct;
  logic        r_best_sharp;
  logic [3:0]  r_note_cnt;
  logic [1:0]  r_oct_cnt;

  logic [17:0] w_base;
  logic [26:0] w_value;
  logic [26:0] w_diff;
  logic [26:0] w_f100_in;
  logic        w_range_in;
  logic        w_better;
  logic        w_above;
  logic        w_last;
  logic [3:0]  w_sel_note;
  logic [1:0]  w_sel_oct;
  logic        w_sel_sharp;

  // Octave-3 semitone frequencies scaled by 100, indexed by note.
  always_comb begin
    w_base = 18'd13081;
    case (r_note_cnt)
      4'd0:    w_base = 18'd13081;
      4'd1:    w_base = 18'd13859;
      4'd2:    w_base = 18'd14683;
      4'd3:    w_base = 18'd15556;
      4'd4:    w_base = 18'd16481;
      4'd5:    w_base = 18'd17461;
      4'd6:    w_base = 18'd18500;
      4'd7:    w_base = 18'd19600;
      4'd8:    w_base = 18'd20765;
      4'd9:    w_base = 18'd22000;
      4'd10:   w_base = 18'd23308;
      4'd11:   w_base = 18'd24694;
      default: w_base = 18'd13081;
    endcase
  end

  assign w_value    = {9'd0, w_base} << r_oct_cnt;
  assign w_f100_in  = 27'(freq_in) * 27'd100;
  assign w_range_in = (freq_in < LP_FMIN) || (freq_in > LP_FMAX);

  // Distance of the current candidate and whether it beats the best so far.
  always_comb begin
    w_above  = (r_f100 > w_value);
    w_diff   = w_above ? (r_f100 - w_value) : (w_value - r_f100);
    w_better = (w_diff < r_best_diff);
    w_last   = (r_note_cnt == 4'd11) && (r_oct_cnt == 2'd3);
  end

  // Final pick including the last candidate, used when leaving SCAN.
  always_comb begin
    w_sel_note  = r_best_note;
    w_sel_oct   = r_best_oct;
    w_sel_sharp = r_best_sharp;
    if (w_better) begin
      w_sel_note  = r_note_cnt;
      w_sel_oct   = r_oct_cnt;
      w_sel_sharp = w_above;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_f100       <= '0;
      r_range      <= 1'b0;
      r_best_diff  <= '1;
      r_best_note  <= '0;
      r_best_oct   <= '0;
      r_best_sharp <= 1'b0;
      r_note_cnt   <= '0;
      r_oct_cnt    <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      note         <= '0;
      octave       <= '0;
      sharp        <= 1'b0;
      out_range    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_f100       <= w_f100_in;
            r_range      <= w_range_in;
            r_best_diff  <= '1;
            r_best_note  <= '0;
            r_best_oct   <= '0;
            r_best_sharp <= 1'b0;
            r_note_cnt   <= '0;
            r_oct_cnt    <= '0;
            in_ready     <= 1'b0;
            r_state      <= SCAN;
          end
        end
        SCAN: begin
          if (w_better) begin
            r_best_diff  <= w_diff;
            r_best_note  <= r_note_cnt;
            r_best_oct   <= r_oct_cnt;
            r_best_sharp <= w_above;
          end
          if (w_last) begin
            note      <= w_sel_note;
            octave    <= w_sel_oct;
            sharp     <= w_sel_sharp;
            out_range <= r_range;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else if (r_note_cnt == 4'd11) begin
            r_note_cnt <= '0;
            r_oct_cnt  <= r_oct_cnt + 2'd1;
          end else begin
            r_note_cnt <= r_note_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_to_note.sv
// Testbench for freq_to_note: directed cases, a reset-mid-scan case, a sweep
// of all 48 grid frequencies and random frequencies, checked against a
// nearest-pitch reference model.
module tb_freq_to_note;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] freq_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  note;
  logic [1:0]  octave;
  logic        sharp;
  logic        out_range;

  int checks = 0;
  int errors = 0;

  int base_tab [12] = '{13081, 13859, 14683, 15556, 16481, 17461,
                        18500, 19600, 20765, 22000, 23308, 24694};

  freq_to_note dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .freq_in(freq_in), .out_valid(out_valid), .out_ready(out_ready),
    .note(note), .octave(octave), .sharp(sharp), .out_range(out_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Nearest pitch on the grid: pitch(k) = base[k%12] * 2^(k/12); first
  // minimum wins, so ties go to the lower pitch.
  task automatic ref_model(input longint f, output int n, output int o,
                           output int s, output int r);
    longint f100, best, v, d;
    f100 = f * 100;
    best = -1;
    n = 0; o = 0; s = 0;
    for (int k = 0; k < 48; k++) begin
      v = longint'(base_tab[k % 12]) * (longint'(1) << (k / 12));
      d = (f100 > v) ? f100 - v : v - f100;
      if (best < 0 || d < best) begin
        best = d; n = k % 12; o = k / 12; s = (f100 > v) ? 1 : 0;
      end
    end
    r = (f < 127 || f > 2034) ? 1 : 0;
  endtask

  // One transaction: request, latency check, result check, optional hold
  // with ignored in_valid pulses, then handshake.
  task automatic txn(input int f, input int hold, input string tag);
    int n, o, s, r, cnt;
    logic [3:0] hn;
    logic [1:0] ho;
    ref_model(longint'(f), n, o, s, r);
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1;
    freq_in  = 20'(f);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " in_ready scan"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      if (cnt == 5) begin
        in_valid = 1'b1;
        freq_in  = 20'd1000;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, cnt, 48);
    chk({tag, " note"}, note, n);
    chk({tag, " octave"}, octave, o);
    chk({tag, " sharp"}, sharp, s);
    chk({tag, " out_range"}, out_range, r);
    if (hold > 0) begin
      hn = note;
      ho = octave;
      for (int i = 0; i < hold; i++) begin
        in_valid = (i % 3 == 0);
        freq_in  = 20'(300 + i);
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold in_ready"}, in_ready, 0);
      chk({tag, " hold note"}, note, hn);
      chk({tag, " hold octave"}, octave, ho);
      chk({tag, " hold note ref"}, note, n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid drop"}, out_valid, 0);
    chk({tag, " in_ready back"}, in_ready, 1);
    chk({tag, " post note"}, note, n);
  endtask

  initial begin
    int n, o, s, r, f, v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst note", note, 0);
    chk("rst octave", octave, 0);
    chk("rst sharp", sharp, 0);
    chk("rst out_range", out_range, 0);
    rst = 1'b0;

    // Directed values with hand-derived expectations.
    txn(440, 0, "a4");
    chk("a4 hand note", note, 9);
    chk("a4 hand octave", octave, 1);
    chk("a4 hand sharp", sharp, 0);
    txn(131, 0, "c3s");
    chk("c3s hand sharp", sharp, 1);
    txn(1976, 0, "b6s");
    chk("b6s hand note", note, 11);
    chk("b6s hand octave", octave, 3);
    chk("b6s hand sharp", sharp, 1);
    txn(100, 0, "low");
    chk("low hand range", out_range, 1);
    txn(0, 0, "zero");
    chk("zero hand note", note, 0);
    chk("zero hand range", out_range, 1);
    txn(2034, 0, "fmax");
    txn(2035, 0, "fmax+1");
    txn(127, 0, "fmin");
    txn(126, 0, "fmin-1");
    txn(1048575, 0, "maxin");
    txn(440, 10, "stall");

    // Reset during the scan.
    @(negedge clk);
    in_valid = 1'b1;
    freq_in  = 20'd440;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst note", note, 0);
    chk("mid rst octave", octave, 0);
    chk("mid rst sharp", sharp, 0);
    chk("mid rst out_range", out_range, 0);
    repeat (2) @(negedge clk);
    chk("mid rst hold in_ready", in_ready, 1);
    rst = 1'b0;
    txn(262, 0, "c4s");
    chk("c4s hand note", note, 0);
    chk("c4s hand octave", octave, 1);
    chk("c4s hand sharp", sharp, 1);

    // Sweep of every grid frequency rounded to Hz.
    for (int k = 0; k < 48; k++) begin
      v = base_tab[k % 12] * (1 << (k / 12));
      f = (v + 50) / 100;
      txn(f, 0, $sformatf("sweep%0d", k));
      chk($sformatf("sweep%0d self note", k), note, k % 12);
      chk($sformatf("sweep%0d self oct", k), octave, k / 12);
    end

    // Random frequencies, mostly around the musical range.
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) f = int'($urandom_range(0, 1048575));
      else            f = int'($urandom_range(0, 2200));
      txn(f, (i % 7 == 0) ? 3 : 0, $sformatf("rnd%0d f=%0d", i, f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
